// File: rtl/ascon_perm_ctrl.sv
// ascon_perm_ctrl: sequences the Ascon permutation p^a / p^b over a 320-bit state.
// Two valid/ready handshakes: requests in, permuted state out, held until consumed.
// Optional build macro ASCON_PERM_UNROLL2_EN: two rounds per clock (round counts must be even).
module ascon_perm_ctrl #(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 8,
  parameter int unsigned ROUNDS_C = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   rnd_sel,
  input  logic [319:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] state_out,
  output logic         busy
);

  localparam int unsigned W_STATE = 320;
  localparam int unsigned W_WORD  = 64;
  localparam int unsigned W_IDX   = 4;

`ifdef ASCON_PERM_UNROLL2_EN
  localparam logic [W_IDX-1:0] STEP = W_IDX'(2);
`else
  localparam logic [W_IDX-1:0] STEP = W_IDX'(1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_e;

  fsm_e               fsm_q, fsm_d;
  logic [W_STATE-1:0] state_q, state_d;
  logic [W_IDX-1:0]   idx_q, idx_d;
  logic [W_IDX-1:0]   rem_q, rem_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [W_IDX-1:0]   n_sel_c;
  logic [W_STATE-1:0] round1_c;
  logic [W_STATE-1:0] round_nxt_c;

  function automatic logic [W_WORD-1:0] ror64(input logic [W_WORD-1:0] x, input int unsigned n);
    return (x >> n) | (x << (W_WORD - n));
  endfunction

  // One Ascon round: constant addition, bitsliced S-box layer, linear diffusion.
  function automatic logic [W_STATE-1:0] ascon_round(input logic [W_STATE-1:0] s,
                                                      input logic [W_IDX-1:0] i);
    logic [W_WORD-1:0] x0, x1, x2, x3, x4;
    logic [W_WORD-1:0] t0, t1, t2, t3, t4;
    logic [7:0]        rc;
    {x0, x1, x2, x3, x4} = s;
    rc = {4'hF - i, i};
    x2 = x2 ^ {56'd0, rc};
    x0 = x0 ^ x4;  x4 = x4 ^ x3;  x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1;  x1 = x1 ^ t2;  x2 = x2 ^ t3;  x3 = x3 ^ t4;  x4 = x4 ^ t0;
    x1 = x1 ^ x0;  x0 = x0 ^ x4;  x3 = x3 ^ x2;  x2 = ~x2;
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  // Round count for the requested permutation flavour.
  always_comb begin
    n_sel_c = W_IDX'(ROUNDS_A);
    case (rnd_sel)
      2'd1:    n_sel_c = W_IDX'(ROUNDS_B);
      2'd2:    n_sel_c = W_IDX'(ROUNDS_C);
      default: n_sel_c = W_IDX'(ROUNDS_A);
    endcase
  end

  // Round datapath: one round, or two chained rounds in the unrolled build.
  assign round1_c = ascon_round(state_q, idx_q);
`ifdef ASCON_PERM_UNROLL2_EN
  assign round_nxt_c = ascon_round(round1_c, idx_q + W_IDX'(1));
`else
  assign round_nxt_c = round1_c;
`endif

  // State and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= S_IDLE;
      state_q     <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic; handshake outputs are registered from the next FSM state.
  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = state_in;
          rem_d   = n_sel_c;
          idx_d   = W_IDX'(12) - n_sel_c;
          fsm_d   = S_RUN;
        end
      end
      S_RUN: begin
        state_d = round_nxt_c;
        idx_d   = idx_q + STEP;
        rem_d   = rem_q - STEP;
        if (rem_q <= STEP) fsm_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
    in_ready_d  = (fsm_d == S_IDLE);
    out_valid_d = (fsm_d == S_DONE);
    busy_d      = (fsm_d != S_IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Bench for ascon_perm_ctrl: random requests checked every cycle against a
// table-driven Ascon model and a cycle-count handshake model.
module tb_ascon_perm_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   rnd_sel = 2'd0;
  logic [319:0] state_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [319:0] state_out;
  logic         busy;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  ascon_perm_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rnd_sel(rnd_sel), .state_in(state_in), .out_valid(out_valid),
    .out_ready(out_ready), .state_out(state_out), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam int SBOX [32] = '{4, 11, 31, 20, 26, 21, 9, 2, 27, 5, 8, 18, 29, 3, 6, 28,
                               30, 19, 7, 14, 0, 13, 17, 24, 16, 12, 1, 25, 22, 10, 15, 23};
  localparam int ROT [5][2] = '{'{19, 28}, '{61, 39}, '{1, 6}, '{10, 17}, '{7, 41}};

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_rc(input int i);
    return 8'((15 - i) * 16 + i);
  endfunction

  function automatic logic [63:0] m_ror(input logic [63:0] x, input int n);
    logic [63:0] y;
    for (int j = 0; j < 64; j++) y[j] = x[(j + n) % 64];
    return y;
  endfunction

  function automatic logic [319:0] m_round(input logic [319:0] s, input int i);
    logic [63:0] x [5];
    logic [4:0]  col;
    logic [4:0]  v;
    logic [319:0] r;
    for (int w = 0; w < 5; w++) x[w] = s[319 - 64 * w -: 64];
    x[2][7:0] = x[2][7:0] ^ m_rc(i);
    for (int b = 0; b < 64; b++) begin
      for (int w = 0; w < 5; w++) col[4 - w] = x[w][b];
      v = 5'(SBOX[col]);
      for (int w = 0; w < 5; w++) x[w][b] = v[4 - w];
    end
    for (int w = 0; w < 5; w++)
      x[w] = x[w] ^ m_ror(x[w], ROT[w][0]) ^ m_ror(x[w], ROT[w][1]);
    for (int w = 0; w < 5; w++) r[319 - 64 * w -: 64] = x[w];
    return r;
  endfunction

  function automatic int m_rounds(input logic [1:0] sel);
    case (sel)
      2'd1:    return 8;
      2'd2:    return 6;
      default: return 12;
    endcase
  endfunction

  function automatic int m_lat(input logic [1:0] sel);
`ifdef ASCON_PERM_UNROLL2_EN
    return m_rounds(sel) / 2;
`else
    return m_rounds(sel);
`endif
  endfunction

  function automatic logic [319:0] m_perm(input logic [319:0] s, input int n);
    logic [319:0] r = s;
    for (int i = 12 - n; i < 12; i++) r = m_round(r, i);
    return r;
  endfunction

  function automatic logic [319:0] rnd320();
    logic [319:0] r;
    for (int k = 0; k < 10; k++) r[32 * k +: 32] = $urandom;
    return r;
  endfunction

  // Behavioural handshake model: idle / counting down / holding result.
  bit           m_idle = 1'b1;
  bit           m_valid = 1'b0;
  bit           m_zero = 1'b1;
  int           m_wait = 0;
  int           cyc = 0;
  logic [319:0] m_result = '0;
  int           acc_cyc [$];
  int           acc_sel [$];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_idle = 1'b1; m_valid = 1'b0; m_wait = 0; m_zero = 1'b1; m_result = '0;
    end else begin
      cyc++;
      if (m_idle) begin
        if (in_valid) begin
          m_idle = 1'b0; m_zero = 1'b0;
          m_wait = m_lat(rnd_sel);
          m_result = m_perm(state_in, m_rounds(rnd_sel));
          acc_cyc.push_back(cyc);
          acc_sel.push_back(int'(rnd_sel));
        end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0; m_idle = 1'b1;
      end
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("in_ready", 320'(in_ready), 320'(m_idle));
      chk("out_valid", 320'(out_valid), 320'(m_valid));
      chk("busy", 320'(busy), 320'(!m_idle));
      if (m_valid) chk("state_out", state_out, m_result);
      if (m_zero) chk("state_zero", state_out, '0);
    end
  end

  task automatic req(input logic [1:0] sel, input logic [319:0] st, input int hold,
                     input int exp_lat, input string nm);
    int cnt = 0;
    @(posedge clk); #2;
    in_valid = 1'b1; rnd_sel = sel; state_in = st;
    @(posedge clk); #2;
    in_valid = 1'b0; rnd_sel = 2'($urandom); state_in = rnd320();
    chk({nm, "_in_ready_drop"}, 320'(in_ready), 320'(0));
    forever begin
      @(posedge clk); cnt++; #1;
      if (out_valid || cnt > 40) break;
    end
    chk({nm, "_latency"}, 320'(cnt), 320'(exp_lat));
    repeat (hold) begin
      @(posedge clk); #2;
      in_valid = 1'($urandom); rnd_sel = 2'($urandom); state_in = rnd320();
    end
    #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [319:0] tmp;
    logic [1:0]   s;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 320'(in_ready), 320'(1));
    chk("rst_out_valid", 320'(out_valid), 320'(0));
    chk("rst_busy", 320'(busy), 320'(0));
    chk("rst_state", state_out, '0);

    // Pin the model with hand-computed values.
    chk("pin_rc0", 320'(m_rc(0)), 320'(8'hF0));
    chk("pin_rc6", 320'(m_rc(6)), 320'(8'h96));
    chk("pin_rc11", 320'(m_rc(11)), 320'(8'h4B));
    tmp = m_round('0, 6);
    chk("pin_round_x0", 320'(tmp[319:256]), 320'(64'h0012C96000000096));
    chk("pin_round_x3", 320'(tmp[127:64]), 320'(64'h25CB000000000096));
    chk("pin_round_x4", 320'(tmp[63:0]), 320'(64'h0));

    req(2'd2, '0, 0, m_lat(2'd2), "p6_zero");
    tmp = rnd320();
    req(2'd0, tmp, 1, m_lat(2'd0), "p12_sel0");
    req(2'd3, tmp, 1, m_lat(2'd3), "p12_sel3");
    req(2'd1, rnd320(), 10, m_lat(2'd1), "p8_hold");

    // Back-to-back requests with out_ready held high.
    acc_cyc.delete(); acc_sel.delete();
    @(posedge clk); #2;
    in_valid = 1'b1; out_ready = 1'b1; state_in = rnd320(); rnd_sel = 2'($urandom);
    repeat (60) begin
      @(posedge clk); #2;
      state_in = rnd320(); rnd_sel = 2'($urandom);
    end
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2 out_ready = 1'b0;
    chk("b2b_count_ok", 320'(acc_cyc.size() >= 4), 320'(1));
    for (int k = 1; k < acc_cyc.size(); k++)
      chk("b2b_spacing", 320'(acc_cyc[k] - acc_cyc[k-1]), 320'(m_lat(2'(acc_sel[k-1])) + 2));

    // Asynchronous reset in the middle of a p12.
    @(posedge clk); #2;
    in_valid = 1'b1; rnd_sel = 2'd0; state_in = rnd320();
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 320'(out_valid), 320'(0));
    chk("arst_in_ready", 320'(in_ready), 320'(1));
    chk("arst_busy", 320'(busy), 320'(0));
    chk("arst_state", state_out, '0);
    @(posedge clk); #2;
    rst = 1'b0;
    req(2'd1, rnd320(), 2, m_lat(2'd1), "p8_after_rst");

    // Random traffic.
    repeat (8) begin
      s = 2'($urandom);
      req(s, rnd320(), int'($urandom_range(0, 4)), m_lat(s), "rand");
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
